// File: rtl/alu_pkg.sv
// Shared constants for the nibble-serial ALU sequencer: opcodes, FSM states
// and the slice width.
package alu_pkg;

    localparam int ALU_SLICE_W = 4;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_AND = 2'b10;
    localparam logic [1:0] ALU_OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_nibble.sv
// Purely combinational 4-bit ALU slice; SUB expects the caller to supply
// carry-in = 1 on the least-significant nibble.
module alu_nibble
    import alu_pkg::*;
(
    input  logic [ALU_SLICE_W-1:0] a,
    input  logic [ALU_SLICE_W-1:0] b,
    input  logic [1:0]             opcode,
    input  logic                   cin,
    output logic [ALU_SLICE_W-1:0] r,
    output logic                   cout
);

    logic [ALU_SLICE_W:0] sum;

    always_comb begin
        sum  = '0;
        r    = '0;
        cout = 1'b0;
        case (opcode)
            ALU_OP_ADD: begin
                sum  = {1'b0, a} + {1'b0, b} + {{ALU_SLICE_W{1'b0}}, cin};
                r    = sum[ALU_SLICE_W-1:0];
                cout = sum[ALU_SLICE_W];
            end
            ALU_OP_SUB: begin
                sum  = {1'b0, a} + {1'b0, ~b} + {{ALU_SLICE_W{1'b0}}, cin};
                r    = sum[ALU_SLICE_W-1:0];
                cout = sum[ALU_SLICE_W];
            end
            ALU_OP_AND: r = a & b;
            default:    r = a | b;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Nibble-serial WIDTH-bit ADD/SUB/AND/OR sequencer around one shared 4-bit slice.
// Optional result flags (out_zero/out_neg/out_ovf) are enabled by ALU_SEQ_FLAGS_EN.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_opcode,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             busy
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
`endif
);

    localparam int NSLICES = WIDTH / ALU_SLICE_W;
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    alu_state_t             state_reg, state_next;
    logic [WIDTH-1:0]       a_reg, b_reg;
    logic [1:0]             op_reg;
    logic                   carry_reg, carry_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [WIDTH-1:0]       result_reg, result_next;

    logic [ALU_SLICE_W-1:0] a_nib [NSLICES];
    logic [ALU_SLICE_W-1:0] b_nib [NSLICES];
    logic [ALU_SLICE_W-1:0] slice_a, slice_b, slice_r;
    logic                   slice_cout;
    logic                   accept;
    logic                   last_run;

    // Split the captured operands into nibbles and steer the slice result
    // back into its own nibble of the result register.
    genvar gi;
    generate
        for (gi = 0; gi < NSLICES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*ALU_SLICE_W +: ALU_SLICE_W];
            assign b_nib[gi] = b_reg[gi*ALU_SLICE_W +: ALU_SLICE_W];
            assign result_next[gi*ALU_SLICE_W +: ALU_SLICE_W] =
                (state_reg == ST_RUN && idx_reg == IDX_W'(gi)) ?
                slice_r : result_reg[gi*ALU_SLICE_W +: ALU_SLICE_W];
        end
    endgenerate

    assign slice_a  = a_nib[idx_reg];
    assign slice_b  = b_nib[idx_reg];
    assign accept   = (state_reg == ST_IDLE) && in_valid;
    assign last_run = (state_reg == ST_RUN) && (idx_reg == LAST_IDX);

    alu_nibble u_slice (
        .a      (slice_a),
        .b      (slice_b),
        .opcode (op_reg),
        .cin    (carry_reg),
        .r      (slice_r),
        .cout   (slice_cout)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        carry_next = carry_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_RUN;
                    idx_next   = '0;
                    // SUB is a + ~b + 1, so the first nibble starts with carry 1
                    carry_next = (in_opcode == ALU_OP_ADD) ? in_cin :
                                 (in_opcode == ALU_OP_SUB);
                end
            end
            ST_RUN: begin
                carry_next = slice_cout;
                if (idx_reg == LAST_IDX) state_next = ST_DONE;
                else                     idx_next   = idx_reg + 1'b1;
            end
            ST_DONE: begin
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            carry_reg  <= 1'b0;
            idx_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            carry_reg  <= carry_next;
            result_reg <= result_next;
            if (accept) begin
                a_reg  <= in_a;
                b_reg  <= in_b;
                op_reg <= in_opcode;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic zero_reg, neg_reg, ovf_reg;
    logic b_msb_eff;
    logic arith_op;

    assign b_msb_eff = (op_reg == ALU_OP_SUB) ? ~slice_b[ALU_SLICE_W-1] : slice_b[ALU_SLICE_W-1];
    assign arith_op  = (op_reg == ALU_OP_ADD) || (op_reg == ALU_OP_SUB);

    // Overflow when both effective operand signs agree but the result sign differs;
    // equivalent to carry-into-MSB XOR carry-out of the top slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_reg <= 1'b0;
            neg_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (last_run) begin
            zero_reg <= (result_next == '0);
            neg_reg  <= slice_r[ALU_SLICE_W-1];
            ovf_reg  <= arith_op && (slice_a[ALU_SLICE_W-1] == b_msb_eff) &&
                        (slice_r[ALU_SLICE_W-1] != slice_a[ALU_SLICE_W-1]);
        end
    end

    assign out_zero = zero_reg;
    assign out_neg  = neg_reg;
    assign out_ovf  = ovf_reg;
`else
    logic unused_last_run;
    assign unused_last_run = last_run;
`endif

    assign in_ready   = (state_reg == ST_IDLE);
    assign out_valid  = (state_reg == ST_DONE);
    assign busy       = (state_reg != ST_IDLE);
    assign out_result = result_reg;
    assign out_cout   = carry_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed scoreboard bench for alu_seq_ctrl (WIDTH=16); flag checks are
// included when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    localparam int WIDTH   = 16;
    localparam int NSLICES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [1:0]       in_opcode = '0;
    logic             in_cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic             out_cout;
    logic             busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic             out_zero, out_neg, out_ovf;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             cout;
        logic             zero;
        logic             neg;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .in_cin     (in_cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout),
        .busy       (busy)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic, signed overflow from a sign-extended sum
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [1:0] op, input logic cin);
        exp_t             e;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   s;
        logic [WIDTH:0]   sx;
        logic             c;
        e  = '0;
        bb = (op == ALU_OP_SUB) ? ~b : b;
        c  = (op == ALU_OP_SUB) ? 1'b1 : cin;
        s  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
        sx = {a[WIDTH-1], a} + {bb[WIDTH-1], bb} + {{WIDTH{1'b0}}, c};
        case (op)
            ALU_OP_AND: e.result = a & b;
            ALU_OP_OR:  e.result = a | b;
            default: begin
                e.result = s[WIDTH-1:0];
                e.cout   = s[WIDTH];
                e.ovf    = sx[WIDTH] ^ sx[WIDTH-1];
            end
        endcase
        e.zero = (e.result == '0);
        e.neg  = e.result[WIDTH-1];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] op, input logic cin);
        check("in_ready_idle", in_ready, 1);
        in_a = a; in_b = b; in_opcode = op; in_cin = cin; in_valid = 1'b1;
        sb_q.push_back(model(a, b, op, cin));
        tick();
        in_valid = 1'b0;
        // Scramble inputs during RUN: result must depend only on the captured values
        in_a = ~a; in_b = ~b; in_opcode = ~op; in_cin = ~cin;
        check("in_ready_run", in_ready, 0);
        check("busy_run", busy, 1);
    endtask

    task automatic wait_done();
        int cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
            if (!out_valid && in_ready !== 1'b0) check("in_ready_run_hold", in_ready, 0);
        end
        check("latency", cycles, NSLICES);
    endtask

    task automatic compare_out(output exp_t e);
        e = '0;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_empty: observed result %0h with no expected entry", out_result);
            return;
        end
        e = sb_q.pop_front();
        check("out_valid", out_valid, 1);
        check("out_result", out_result, e.result);
        check("out_cout", out_cout, e.cout);
`ifdef ALU_SEQ_FLAGS_EN
        check("out_zero", out_zero, e.zero);
        check("out_neg", out_neg, e.neg);
        check("out_ovf", out_ovf, e.ovf);
`endif
        $display("op result=%h cout=%0d (expected %h/%0d)", out_result, out_cout, e.result, e.cout);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_hs", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] op, input logic cin);
        exp_t e;
        issue(a, b, op, cin);
        wait_done();
        compare_out(e);
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op(16'hFFFF, 16'h0001, ALU_OP_ADD, 1'b0);
        run_op(16'h0005, 16'h0007, ALU_OP_SUB, 1'b0);
        run_op(16'h1234, 16'h1234, ALU_OP_SUB, 1'b1);
        run_op(16'hF0F0, 16'h3C3C, ALU_OP_AND, 1'b1);
        run_op(16'hF0F0, 16'h3C3C, ALU_OP_OR,  1'b0);
        run_op(16'h00FF, 16'h0F00, ALU_OP_ADD, 1'b1);
        run_op(16'h7FFF, 16'h0001, ALU_OP_ADD, 1'b0);
        run_op(16'h8000, 16'h0001, ALU_OP_SUB, 1'b0);

        // Backpressure: DONE held for 5 cycles while a second request is offered
        issue(16'hABCD, 16'h1234, ALU_OP_ADD, 1'b1);
        wait_done();
        compare_out(e);
        in_a = 16'h5555; in_b = 16'h0101; in_opcode = ALU_OP_OR; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_result", out_result, e.result);
            check("bp_out_cout", out_cout, e.cout);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        consume();

        // Asynchronous reset in the second RUN cycle aborts the operation
        issue(16'h1111, 16'h2222, ALU_OP_ADD, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("abort_out_valid", out_valid, 0);
        check("abort_out_result", out_result, 0);
        check("abort_out_cout", out_cout, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(16'h0001, 16'h0002, ALU_OP_ADD, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
